// File: rtl/fir_interp2.sv
// Interpolate-by-2 polyphase FIR built on the prototype [-1 3.75 3.75 -1].
// One signed sample in per handshake, two full-precision outputs (x4 scaled) out.
//
// Handshake contract (both ports): a transfer happens on a rising clk edge
// where valid && ready are both high. A producer holding valid high keeps
// its data stable until that edge and never withdraws valid early. y_valid
// never drops and y never changes while an output is waiting on y_ready.
module fir_interp2 #(
  parameter int W  = 8,
  parameter int YW = W + 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [W-1:0]  x,
  input  logic                 x_valid,
  output logic                 x_ready,
  output logic signed [YW-1:0] y,
  output logic                 y_valid,
  input  logic                 y_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH0  = 2'd1,
    PH1  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [W-1:0]  tap0;
  logic signed [W-1:0]  tap1;
  logic signed [YW-1:0] x_ext;
  logic signed [YW-1:0] tap0_ext;
  logic signed [YW-1:0] tap1_ext;
  logic signed [YW-1:0] p0;
  logic signed [YW-1:0] p1;
  logic                 accept;
  logic                 load_p0;
  logic                 load_p1;

  // Operands are widened before any arithmetic so the result is exact.
  assign x_ext    = {{(YW-W){x[W-1]}}, x};
  assign tap0_ext = {{(YW-W){tap0[W-1]}}, tap0};
  assign tap1_ext = {{(YW-W){tap1[W-1]}}, tap1};

  // Even phase pairs the incoming sample with the newest stored tap;
  // odd phase uses both stored taps after the delay line has shifted.
  // 15*a is formed as 16*a - a.
  assign p0 = (tap0_ext <<< 4) - tap0_ext - (x_ext <<< 2);
  assign p1 = (tap0_ext <<< 4) - tap0_ext - (tap1_ext <<< 2);

  // A new sample is taken only when nothing is pending or the last odd
  // output is leaving this cycle, which yields 1 input per 2 cycles.
  assign x_ready = !reset && ((state == IDLE) || ((state == PH1) && y_ready));
  assign accept  = x_valid && x_ready;
  assign y_valid = (state != IDLE);

  // Next-state and datapath-load decisions.
  always_comb begin
    state_next = state;
    load_p0    = 1'b0;
    load_p1    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = PH0;
          load_p0    = 1'b1;
        end
      end
      PH0: begin
        if (y_ready) begin
          state_next = PH1;
          load_p1    = 1'b1;
        end
      end
      PH1: begin
        if (y_ready) begin
          if (accept) begin
            state_next = PH0;
            load_p0    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, delay line and output register; reset discards any pending output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tap0  <= '0;
      tap1  <= '0;
      y     <= '0;
    end else begin
      state <= state_next;
      if (load_p0) begin
        y    <= p0;
        tap1 <= tap0;
        tap0 <= x;
      end else if (load_p1) begin
        y <= p1;
      end
    end
  end

endmodule

// File: tb/tb_fir_interp2.sv
// Self-checking bench for fir_interp2: task per scenario, scoreboard queue of
// expected outputs filled at each accepted input from a small reference model.
module tb_fir_interp2;

  localparam int W  = 8;
  localparam int YW = W + 5;

  logic                 clk;
  logic                 reset;
  logic signed [W-1:0]  x;
  logic                 x_valid;
  logic                 x_ready;
  logic signed [YW-1:0] y;
  logic                 y_valid;
  logic                 y_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int accept_cyc;

  logic [YW-1:0] exp_q[$];

  // Reference model delay line.
  int m_tap0 = 0;
  int m_tap1 = 0;

  // Output-hold tracking for the stability check.
  logic          held = 1'b0;
  logic [YW-1:0] held_y;

  fir_interp2 #(.W(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .x      (x),
    .x_valid(x_valid),
    .x_ready(x_ready),
    .y      (y),
    .y_valid(y_valid),
    .y_ready(y_ready)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: compares every completed output transfer and checks
  // that a stalled output stays put.
  always @(negedge clk) begin
    if (reset) begin
      held <= 1'b0;
    end else begin
      if (held && y_valid) begin
        checks++;
        if (y !== held_y) begin
          failures++;
          $display("FAIL y_stable: y=%0d required=%0d", $signed(y), $signed(held_y));
        end
      end
      if (y_valid && y_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL y_unexpected: y=%0d required=no output", $signed(y));
        end else begin
          logic [YW-1:0] e;
          e = exp_q.pop_front();
          if (y !== e) begin
            failures++;
            $display("FAIL y_value: y=%0d required=%0d", $signed(y), $signed(e));
          end
        end
        held <= 1'b0;
      end else if (y_valid) begin
        held   <= 1'b1;
        held_y <= y;
      end else begin
        held <= 1'b0;
      end
    end
  end

  task automatic do_reset();
    reset   = 1'b1;
    x_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    m_tap0 = 0;
    m_tap1 = 0;
  endtask

  // Offer one sample; push its two expected outputs when the accept edge comes.
  task automatic feed(input logic signed [W-1:0] v, output int waited);
    bit got;
    int e0;
    int e1;
    got     = 1'b0;
    waited  = 0;
    x       = v;
    x_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (x_ready) begin
        got = 1'b1;
        accept_cyc = cyc;
        e0 = 15 * m_tap0 - 4 * int'(v);
        m_tap1 = m_tap0;
        m_tap0 = int'(v);
        e1 = 15 * m_tap0 - 4 * m_tap1;
        exp_q.push_back(YW'(e0));
        exp_q.push_back(YW'(e1));
        @(posedge clk);
        #1;
        break;
      end
      waited++;
    end
    x_valid = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL feed_timeout: x=%0d accepted=0 required=1", v);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !y_valid) break;
    end
    checks++;
    if (exp_q.size() != 0 || y_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain: pending=%0d y_valid=%b required pending=0 y_valid=0",
               name, exp_q.size(), y_valid);
    end
  endtask

  task automatic test_reset();
    int w;
    reset   = 1'b1;
    x_valid = 1'b1;
    x       = 8'sd5;
    y_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (y_valid !== 1'b0 || y !== '0 || x_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: y_valid=%b y=%0d x_ready=%b required 0 0 0",
               y_valid, $signed(y), x_ready);
    end
    @(posedge clk);
    #1;
    reset   = 1'b0;
    x_valid = 1'b0;
    exp_q.delete();
    m_tap0 = 0;
    m_tap1 = 0;
    @(negedge clk);
    checks++;
    if (x_ready !== 1'b1 || y_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: x_ready=%b y_valid=%b required 1 0", x_ready, y_valid);
    end
    w = 0;
  endtask

  task automatic test_impulse();
    int w;
    do_reset();
    y_ready = 1'b1;
    feed(8'sd64, w);
    checks++;
    if (exp_q[0] !== 13'h1f00) begin
      failures++;
      $display("FAIL impulse_model: p0=%0d required=-256", $signed(exp_q[0]));
    end
    feed(8'sd0, w);
    wait_drain("impulse");
  endtask

  task automatic test_dc_min();
    int w;
    int first;
    do_reset();
    y_ready = 1'b1;
    feed(-8'sd128, w);
    first = accept_cyc;
    for (int i = 0; i < 7; i++) feed(-8'sd128, w);
    checks++;
    if (accept_cyc - first != 14) begin
      failures++;
      $display("FAIL dc_throughput: span=%0d cycles required=14", accept_cyc - first);
    end
    wait_drain("dc_min");
  endtask

  task automatic test_alternation();
    int w;
    do_reset();
    y_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      feed(8'sd127, w);
      feed(-8'sd128, w);
    end
    wait_drain("alternation");
  endtask

  task automatic test_back_pressure();
    int w;
    do_reset();
    y_ready = 1'b0;
    feed(8'sd64, w);
    x       = 8'sd0;
    x_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (y_valid !== 1'b1 || y !== 13'h1f00 || x_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold: y_valid=%b y=%0d x_ready=%b required 1 -256 0",
                 y_valid, $signed(y), x_ready);
      end
      @(posedge clk);
      #1;
    end
    y_ready = 1'b1;
    feed(8'sd0, w);
    checks++;
    if (w != 1) begin
      failures++;
      $display("FAIL bp_accept_phase: waited=%0d cycles required=1", w);
    end
    wait_drain("back_pressure");
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    y_ready = 1'b0;
    feed(8'sd64, w);
    reset   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (y_valid !== 1'b0 || y !== '0) begin
      failures++;
      $display("FAIL reset_mid: y_valid=%b y=%0d required 0 0", y_valid, $signed(y));
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    m_tap0  = 0;
    m_tap1  = 0;
    y_ready = 1'b1;
    feed(8'sd0, w);
    wait_drain("reset_mid");
  endtask

  task automatic test_idle_gap();
    int w;
    do_reset();
    y_ready = 1'b1;
    feed(8'sd64, w);
    wait_drain("idle_gap_first");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (y_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_valid: y_valid=%b required=0", y_valid);
      end
    end
    @(posedge clk);
    #1;
    feed(8'sd0, w);
    wait_drain("idle_gap");
  endtask

  task automatic test_random();
    int  w;
    bit  done;
    done = 1'b0;
    do_reset();
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          feed($signed(W'($urandom_range(0, 255))), w);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          y_ready = 1'($urandom_range(0, 1));
        end
        y_ready = 1'b1;
      end
    join
    wait_drain("random");
  endtask

  initial begin
    x       = '0;
    x_valid = 1'b0;
    y_ready = 1'b1;
    reset   = 1'b1;
    test_reset();
    test_impulse();
    test_dc_min();
    test_alternation();
    test_back_pressure();
    test_reset_mid();
    test_idle_gap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a scenario stalls beyond its own bounds.
  initial begin
    #500000;
    $display("FAIL global_timeout: finished=0 required=1");
    $fatal(1, "timeout");
  end

endmodule
